dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port 128x32 data SRAM (HSs18n_128x32) between the SingleCycle_MIPS load/store port and a host/loader port. The host port is used for preloading data and reading results back. The core has priority because its single-cycle datapath needs same-cycle read data. A saturating wait counter bounds host starvation by stalling the core for one cycle. The block sits between SingleCycle_MIPS, the host port and the SRAM, and drives the SRAM's active-low CEN/WEN/OEN controls.

## Interface
- AW, 7, address width (word address)
- DW, 32, data width
- MAX_WAIT, 4, host cycles refused before a forced grant; legal range 1..15

- clk  in  1  system clock; the SRAM is clocked on ~clk
- rst_n  in  1  synchronous, active-low reset
- core_req  in  1  core memory access this cycle
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  core word address
- core_wdata  in  DW  core write data
- core_rdata  out  DW  read data, combinational from mem_q
- core_stall  out  1  core access not performed this cycle; core holds PC and request
- host_valid  in  1  host request present
- host_ready  out  1  host request accepted this cycle
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host word address
- host_wdata  in  DW  host write data
- host_rvalid  out  1  registered; host_rdata valid
- host_rdata  out  DW  registered host read data
- mem_cen  out  1  SRAM chip enable, active low
- mem_wen  out  1  SRAM write enable, active low
- mem_oen  out  1  SRAM output enable, active low
- mem_a  out  AW  SRAM address
- mem_d  out  DW  SRAM write data
- mem_q  in  DW  SRAM read data

## Operation
- Exactly one SRAM access per cycle. Grant is combinational from the current inputs and the wait_cnt register.
- force = (wait_cnt == MAX_WAIT).
- Grant priority:
  - force && host_valid: host granted; core_stall = core_req.
  - else core_req: core granted; host_ready = 0.
  - else host_valid: host granted.
  - else idle.
- Granted access:
  - mem_cen = 0; mem_a and mem_d come from the winner.
  - mem_wen = ~we. mem_oen = we, so it is 0 on reads.
- Idle: mem_cen = mem_wen = mem_oen = 1; mem_a and mem_d = 0.
- wait_cnt (4 bits):
  - cleared when host_valid = 0 or host_ready = 1;
  - otherwise incremented, saturating at MAX_WAIT.
- Host handshake:
  - Transfer occurs when host_valid && host_ready.
  - The host holds addr, we and wdata stable while valid && !ready.
  - host_ready never depends on itself.
- Host read: on the accepting clk edge, host_rdata <= mem_q and host_rvalid <= 1. host_rvalid is 1 for exactly one cycle per accepted read.
- Host writes produce no rvalid.
- Core read: core_rdata = mem_q, valid before the next rising clk edge. core_rdata is don't-care when the core is stalled.
- Same address, same cycle is impossible because there is one winner. A write followed by a read of the same address in the next cycle returns the new data.

## Timing
- Reset values:
  - wait_cnt = 0, host_rvalid = 0, host_rdata = 0.
  - While rst_n = 0: host_ready = 0, core_stall = 0, and the SRAM is idle (mem_cen = mem_wen = mem_oen = 1).
- Core read latency is 0 cycles (same cycle). Host read latency is 1 cycle (rvalid in the cycle after acceptance).
- Worst-case host wait is MAX_WAIT refused cycles; acceptance occurs in cycle MAX_WAIT counted from 0.
- The core stalls at most 1 cycle in every MAX_WAIT+1 cycles.
- Reset mid-operation: a read accepted in the cycle before rst_n falls produces no rvalid. The pending handshake is dropped and the host must re-issue.
- host_valid deasserted while waiting: wait_cnt returns to 0 next cycle.

## Structure
- Package dmem_arb_pkg holds:
  - AW, DW and the MAX_WAIT default;
  - localparams CEN_ON = 0 and CEN_OFF = 1, and the equivalent WEN/OEN encodings;
  - typedef mem_req_t {we, addr, wdata}, used for both requesters.
- One sub-module, dmem_starve_cnt: the saturating wait counter with inputs clr and inc and output force.
- The grant mux and the rdata register stay in dmem_arbiter.

## Test plan
- Core read with mem[0] = 15, host idle -> mem_cen = 0, mem_oen = 0, core_rdata = 15 in the same cycle, core_stall = 0.
- Host write addr 4 = 30, core idle -> host_ready = 1 in the same cycle, mem_wen = 0, mem[4] = 30, host_rvalid stays 0.
- Host read addr 1 with mem[1] = 20 -> next cycle host_rvalid = 1 and host_rdata = 20; rvalid = 0 in the following cycle.
- core_req held high and host_valid held high, MAX_WAIT = 4 -> host_ready = 0 in cycles 0-3; cycle 4: host_ready = 1 and core_stall = 1; cycle 5: core granted, wait_cnt = 0.
- Core writes addr 4 = 40, then a host read of addr 4 next cycle -> host_rdata = 40.
- Host read accepted, then rst_n = 0 at the next edge -> host_rvalid never asserts and all SRAM controls are 1 during reset.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared widths, active-low SRAM control encodings and the request record
// used by both requesters of the data SRAM arbiter.
package dmem_arb_pkg;

  localparam int AW               = 7;
  localparam int DW               = 32;
  localparam int MAX_WAIT_DEFAULT = 4;

  // SRAM controls are all active low.
  localparam logic CEN_ON    = 1'b0;
  localparam logic CEN_OFF   = 1'b1;
  localparam logic WEN_WRITE = 1'b0;
  localparam logic WEN_READ  = 1'b1;
  localparam logic OEN_ON    = 1'b0;
  localparam logic OEN_OFF   = 1'b1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of consecutive cycles the host has been refused.
// force_grant rises once the host has waited MAX_WAIT cycles, which lets the
// host take the SRAM ahead of the core for one cycle.
module dmem_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic force_grant
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;

  // Next count: clear wins over increment, increment stops at MAX_CNT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr) begin
      wait_cnt_d = 4'd0;
    end else if (inc && (wait_cnt_q != MAX_CNT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_grant = (wait_cnt_q == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data SRAM between the single-cycle core's
// load/store port and a host/loader port. The core normally wins so it gets
// same-cycle read data; a starved host eventually steals one cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic          mem_oen,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  mem_req_t core_req_s;
  mem_req_t host_req_s;
  mem_req_t win_req;
  logic     grant_core;
  logic     grant_host;
  logic     force_grant;
  logic     host_rvalid_q, host_rvalid_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;

  assign core_req_s = '{we: core_we, addr: core_addr, wdata: core_wdata};
  assign host_req_s = '{we: host_we, addr: host_addr, wdata: host_wdata};

  // Counts refused host cycles; a host waiting with no grant increments it.
  dmem_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (!host_valid || host_ready),
    .inc         (host_valid && !host_ready),
    .force_grant (force_grant)
  );

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    grant_core = 1'b0;
    grant_host = 1'b0;
    core_stall = 1'b0;
    if (rst_n) begin
      if (force_grant && host_valid) begin
        grant_host = 1'b1;
        core_stall = core_req;
      end else if (core_req) begin
        grant_core = 1'b1;
      end else if (host_valid) begin
        grant_host = 1'b1;
      end
    end
  end

  assign host_ready = grant_host;

  // Drive the SRAM from the winner, or park it idle with zeroed buses.
  always_comb begin
    win_req = grant_host ? host_req_s : core_req_s;
    mem_cen = CEN_OFF;
    mem_wen = WEN_READ;
    mem_oen = OEN_OFF;
    mem_a   = '0;
    mem_d   = '0;
    if (grant_host || grant_core) begin
      mem_cen = CEN_ON;
      mem_wen = win_req.we ? WEN_WRITE : WEN_READ;
      mem_oen = win_req.we ? OEN_OFF : OEN_ON;
      mem_a   = win_req.addr;
      mem_d   = win_req.wdata;
    end
  end

  // The SRAM is clocked on the falling edge, so mem_q already holds this
  // cycle's read data by the next rising edge.
  assign core_rdata = mem_q;

  // Capture host read data on the accepting edge; rvalid is a one-cycle pulse.
  always_comb begin
    host_rvalid_d = grant_host && !host_we;
    host_rdata_d  = host_rvalid_d ? mem_q : host_rdata_q;
  end

  // Host read-return registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, core/host contention
// sequences, randomized traffic against a behavioural model, mid-op reset.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_req, core_we, core_stall;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          host_valid, host_ready, host_we, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_cen, mem_wen, mem_oen;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q = '0;

  logic [DW-1:0] sram    [0:127];
  logic [DW-1:0] ref_mem [0:127];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_cen    (mem_cen),
    .mem_wen    (mem_wen),
    .mem_oen    (mem_oen),
    .mem_a      (mem_a),
    .mem_d      (mem_d),
    .mem_q      (mem_q)
  );

  // SRAM model clocked on the falling edge.
  always @(negedge clk) begin
    if (mem_cen == 1'b0) begin
      if (mem_wen == 1'b0) sram[mem_a] <= mem_d;
      else                 mem_q <= sram[mem_a];
    end
  end

  typedef struct {
    logic          creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          hv, hwe;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwd;
    logic          rdy, stl, cen, wen, oen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rchk;
    logic [DW-1:0] rdata;
    logic          rv;
    logic [DW-1:0] hrd;
  } vec_t;

  function automatic vec_t mk(input int creq, cwe, caddr, cwd, hv, hwe, haddr, hwd,
                              input int rdy, stl, cen, wen, oen, a, d,
                              input int rchk, rdata, rv, hrd);
    vec_t v;
    v.creq = creq[0]; v.cwe = cwe[0]; v.caddr = 7'(caddr); v.cwd = 32'(cwd);
    v.hv = hv[0]; v.hwe = hwe[0]; v.haddr = 7'(haddr); v.hwd = 32'(hwd);
    v.rdy = rdy[0]; v.stl = stl[0]; v.cen = cen[0]; v.wen = wen[0]; v.oen = oen[0];
    v.a = 7'(a); v.d = 32'(d); v.rchk = rchk[0]; v.rdata = 32'(rdata);
    v.rv = rv[0]; v.hrd = 32'(hrd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic creq, cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                       input logic hv, hwe, input logic [AW-1:0] haddr, input logic [DW-1:0] hwd);
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    host_valid = hv; host_we = hwe; host_addr = haddr; host_wdata = hwd;
  endtask

  task automatic chk_bus(input string tag, input logic rdy, stl, cen, wen, oen,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, ".host_ready"}, 32'(host_ready), 32'(rdy));
    chk({tag, ".core_stall"}, 32'(core_stall), 32'(stl));
    chk({tag, ".mem_cen"},    32'(mem_cen),    32'(cen));
    chk({tag, ".mem_wen"},    32'(mem_wen),    32'(wen));
    chk({tag, ".mem_oen"},    32'(mem_oen),    32'(oen));
    chk({tag, ".mem_a"},      32'(mem_a),      32'(a));
    chk({tag, ".mem_d"},      mem_d,           d);
  endtask

  task automatic to_neg();
    @(negedge clk); #2;
  endtask

  task automatic to_pos();
    @(posedge clk); #1;
    cyc++;
  endtask

  // Core and host both requesting: host refused MW cycles, forced in at MW.
  // pre_drop > 0 first builds up waiting, then drops host_valid for a cycle,
  // which must restart the full wait.
  task automatic starve(input int pre_drop);
    logic [DW-1:0] wv;
    wv = 32'(99 + pre_drop);
    for (int k = 0; k < pre_drop; k++) begin
      drive(1'b1, 1'b0, 7'd2, 32'd0, 1'b1, 1'b1, 7'd9, wv);
      #1 chk_bus("pre", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd2, 32'd0);
      to_neg(); to_pos();
    end
    if (pre_drop > 0) begin
      drive(1'b1, 1'b0, 7'd2, 32'd0, 1'b0, 1'b1, 7'd9, wv);
      #1 chk_bus("drop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd2, 32'd0);
      to_neg(); to_pos();
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 5) drive(1'b1, 1'b0, 7'd2, 32'd0, 1'b1, 1'b1, 7'd9, wv);
      else       drive(1'b1, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd9, 32'd0);
      #1;
      if (k < 4)       chk_bus($sformatf("starve%0d.c%0d", pre_drop, k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd2, 32'd0);
      else if (k == 4) chk_bus($sformatf("starve%0d.c4", pre_drop), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'd9, wv);
      else             chk_bus($sformatf("starve%0d.c5", pre_drop), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 32'd0);
      to_neg();
      if (k < 4)  chk("starve.core_rdata", core_rdata, ref_mem[2]);
      if (k == 5) chk("starve.core_rdata0", core_rdata, ref_mem[0]);
      to_pos();
      if (k == 4) ref_mem[9] = wv;
    end
    $display("[TB] starve pre_drop=%0d host write addr 9 data %0d forced in", pre_drop, wv);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
    #1 chk_bus("starve.idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
    to_neg(); to_pos();
  endtask

  vec_t vt [13];

  initial begin
    logic          h_pend, h_we_r, c_req, c_we, exp_host, exp_core, hv_now;
    logic [AW-1:0] h_addr_r, c_addr;
    logic [DW-1:0] h_wd_r, c_wd, exp_hrd;
    int            refused, last_stall;

    for (int i = 0; i < 128; i++) begin
      sram[i]    = 32'h1000 + 32'(i);
      ref_mem[i] = 32'h1000 + 32'(i);
    end
    sram[0] = 32'd15; ref_mem[0] = 32'd15;
    sram[1] = 32'd20; ref_mem[1] = 32'd20;

    //        creq cwe ca cwd      hv hwe ha hwd    rdy stl cen wen oen a d        rchk rdata   rv hrd
    vt[0]  = mk(0, 0, 0, 0,        0, 0, 0, 0,      0, 0, 1, 1, 1, 0, 0,        0, 0,       0, 0);
    vt[1]  = mk(1, 0, 0, 'hdead,   0, 0, 0, 0,      0, 0, 0, 1, 0, 0, 'hdead,   1, 15,      0, 0);
    vt[2]  = mk(0, 0, 0, 0,        1, 1, 4, 30,     1, 0, 0, 0, 1, 4, 30,       0, 0,       0, 0);
    vt[3]  = mk(1, 0, 4, 0,        0, 0, 0, 0,      0, 0, 0, 1, 0, 4, 0,        1, 30,      0, 0);
    vt[4]  = mk(1, 1, 4, 40,       0, 0, 0, 0,      0, 0, 0, 0, 1, 4, 40,       0, 0,       0, 0);
    vt[5]  = mk(0, 0, 0, 0,        1, 0, 4, 0,      1, 0, 0, 1, 0, 4, 0,        0, 0,       1, 40);
    vt[6]  = mk(0, 0, 0, 0,        1, 0, 1, 'h55,   1, 0, 0, 1, 0, 1, 'h55,     0, 0,       1, 20);
    vt[7]  = mk(0, 0, 0, 0,        0, 0, 0, 0,      0, 0, 1, 1, 1, 0, 0,        0, 0,       0, 0);
    vt[8]  = mk(1, 0, 1, 7,        1, 1, 5, 77,     0, 0, 0, 1, 0, 1, 7,        1, 20,      0, 0);
    vt[9]  = mk(0, 0, 0, 0,        0, 0, 0, 0,      0, 0, 1, 1, 1, 0, 0,        0, 0,       0, 0);
    vt[10] = mk(0, 0, 0, 0,        1, 1, 6, 'h1234, 1, 0, 0, 0, 1, 6, 'h1234,   0, 0,       0, 0);
    vt[11] = mk(1, 0, 6, 0,        0, 0, 0, 0,      0, 0, 0, 1, 0, 6, 0,        1, 'h1234,  0, 0);
    vt[12] = mk(0, 0, 0, 0,        0, 0, 0, 0,      0, 0, 1, 1, 1, 0, 0,        0, 0,       0, 0);

    // Reset with every request asserted: nothing may reach the SRAM.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 7'd3, 32'd1, 1'b1, 1'b0, 7'd2, 32'd2);
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      #1 chk_bus("rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
      to_neg(); to_pos();
      chk("rst.host_rvalid", 32'(host_rvalid), 32'd0);
      chk("rst.host_rdata", host_rdata, 32'd0);
    end
    $display("[TB] reset held 3 cycles with all requests asserted");
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].creq, vt[i].cwe, vt[i].caddr, vt[i].cwd, vt[i].hv, vt[i].hwe, vt[i].haddr, vt[i].hwd);
      #1 chk_bus($sformatf("vec%0d", i), vt[i].rdy, vt[i].stl, vt[i].cen, vt[i].wen, vt[i].oen, vt[i].a, vt[i].d);
      to_neg();
      if (vt[i].rchk) chk($sformatf("vec%0d.core_rdata", i), core_rdata, vt[i].rdata);
      to_pos();
      chk($sformatf("vec%0d.host_rvalid", i), 32'(host_rvalid), 32'(vt[i].rv));
      if (vt[i].rv) chk($sformatf("vec%0d.host_rdata", i), host_rdata, vt[i].hrd);
      if (vt[i].rdy && vt[i].hwe) ref_mem[vt[i].haddr] = vt[i].hwd;
      if (vt[i].creq && !vt[i].stl && vt[i].cwe) ref_mem[vt[i].caddr] = vt[i].cwd;
      $display("[TB] vec %0d core_req=%0b we=%0b addr=%0d host_valid=%0b we=%0b addr=%0d",
               i, vt[i].creq, vt[i].cwe, vt[i].caddr, vt[i].hv, vt[i].hwe, vt[i].haddr);
    end

    starve(0);
    starve(3);

    // Randomized traffic against the behavioural model.
    h_pend = 1'b0; h_we_r = 1'b0; h_addr_r = '0; h_wd_r = '0;
    refused = 0; last_stall = -100;
    for (int t = 0; t < 600; t++) begin
      c_req  = ($urandom_range(0, 3) != 0);
      c_we   = $urandom_range(0, 1) == 1;
      c_addr = 7'($urandom_range(0, 15));
      c_wd   = $urandom;
      if (!h_pend && $urandom_range(0, 2) == 0) begin
        h_pend = 1'b1; h_we_r = $urandom_range(0, 1) == 1;
        h_addr_r = 7'($urandom_range(0, 15)); h_wd_r = $urandom;
        refused = 0;
      end else if (h_pend && $urandom_range(0, 15) == 0) begin
        h_pend = 1'b0;
      end
      hv_now = h_pend;
      drive(c_req, c_we, c_addr, c_wd, hv_now, h_we_r, h_addr_r, h_wd_r);

      // The host wins if it has been turned away MW times already, or the core is quiet.
      exp_host = hv_now && (refused >= MW || !c_req);
      exp_core = c_req && !exp_host;
      exp_hrd  = ref_mem[h_addr_r];
      #1;
      if (exp_host)
        chk_bus("rnd", 1'b1, c_req, 1'b0, !h_we_r, h_we_r, h_addr_r, h_wd_r);
      else if (exp_core)
        chk_bus("rnd", 1'b0, 1'b0, 1'b0, !c_we, c_we, c_addr, c_wd);
      else
        chk_bus("rnd", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
      if (core_stall) begin
        chk("rnd.stall_spacing", 32'(t - last_stall >= MW + 1), 32'd1);
        last_stall = t;
      end
      to_neg();
      if (exp_core && !c_we) chk("rnd.core_rdata", core_rdata, ref_mem[c_addr]);
      to_pos();
      chk("rnd.host_rvalid", 32'(host_rvalid), 32'(exp_host && !h_we_r));
      if (exp_host && !h_we_r) chk("rnd.host_rdata", host_rdata, exp_hrd);

      if (exp_host && h_we_r) ref_mem[h_addr_r] = h_wd_r;
      if (exp_core && c_we)   ref_mem[c_addr] = c_wd;
      if (exp_host) begin
        $display("[TB] rnd t=%0d host %s addr %0d data %0h after %0d refusals",
                 t, h_we_r ? "wr" : "rd", h_addr_r, h_we_r ? h_wd_r : exp_hrd, refused);
        h_pend = 1'b0;
        refused = 0;
      end else if (hv_now) begin
        refused++;
      end
    end

    // Host read accepted, then reset sampled at the accepting edge.
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd1, 32'd0);
    #1 chk("rstmid.host_ready", 32'(host_ready), 32'd1);
    to_neg();
    rst_n = 1'b0;
    to_pos();
    chk("rstmid.host_rvalid", 32'(host_rvalid), 32'd0);
    drive(1'b1, 1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd1, 32'd0);
    for (int r = 0; r < 2; r++) begin
      #1 chk_bus("rstmid", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
      to_neg(); to_pos();
      chk("rstmid.host_rvalid_hold", 32'(host_rvalid), 32'd0);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 32'd0);
    #1; to_neg(); to_pos();
    chk("rstmid.host_rvalid_after", 32'(host_rvalid), 32'd0);
    chk("rstmid.host_rdata", host_rdata, 32'd0);
    $display("[TB] reset mid-operation dropped pending host read");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
